// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Purpose : Shared types and default widths for the memory arbiter slice.
// Revision: 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int c_addr_w_def = 32;
  localparam int c_data_w_def = 32;

  typedef enum logic [1:0] {
    STAT_IDLE = 2'b00,
    STAT_BUSY = 2'b01,
    STAT_DONE = 2'b10,
    STAT_ERR  = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_GRANT_I = 2'b01,
    S_GRANT_D = 2'b10,
    S_RESP    = 2'b11
  } arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

  // Only meaningful when at least one request is present; contention goes
  // to whichever side was not served last.
  function automatic side_t pick_side(input logic ireq, input logic dreq,
                                      input side_t last);
    if (ireq && dreq) return (last == SIDE_I) ? SIDE_D : SIDE_I;
    else if (dreq)    return SIDE_D;
    else              return SIDE_I;
  endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Two-requester (instruction/data) arbiter onto one memory port,
//           with alternating priority under contention and an ack timeout.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = c_addr_w_def,
  parameter int DATA_W  = c_data_w_def,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic [1:0]          i_status,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [1:0]          d_status,

  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int c_be_w  = DATA_W / 8;
  localparam int c_cnt_w = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  arb_state_t          r_state;
  side_t               r_last;
  logic                r_err;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_m_req;
  logic                r_m_we;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic [c_be_w-1:0]   r_m_be;
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  side_t               w_pick;
  status_t             w_i_status;
  status_t             w_d_status;

  assign w_pick = pick_side(i_req, d_req, r_last);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_last    <= SIDE_I;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_m_be    <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req || d_req) begin
            if (w_pick == SIDE_D) begin
              r_state   <= S_GRANT_D;
              r_m_we    <= d_we;
              r_m_addr  <= d_addr;
              r_m_wdata <= d_wdata;
              r_m_be    <= d_be;
            end else begin
              r_state   <= S_GRANT_I;
              r_m_we    <= 1'b0;
              r_m_addr  <= i_addr;
              r_m_wdata <= '0;
              r_m_be    <= '1;
            end
            r_last  <= w_pick;
            r_m_req <= 1'b1;
            r_cnt   <= '0;
            r_err   <= 1'b0;
          end
        end

        S_GRANT_I, S_GRANT_D: begin
          // An ack on the final permitted cycle still completes normally.
          if (m_ack) begin
            r_m_req <= 1'b0;
            r_err   <= 1'b0;
            r_state <= S_RESP;
            if (!r_m_we) begin
              if (r_state == S_GRANT_D) r_d_rdata <= m_rdata;
              else                      r_i_rdata <= m_rdata;
            end
          end else if (r_cnt == c_cnt_last) begin
            r_m_req <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
            r_cnt   <= r_cnt + 1'b1;
            if (r_state == S_GRANT_D) r_d_rdata <= '0;
            else                      r_i_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_RESP: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Status is forced to IDLE while reset is asserted so no stale pulse leaks.
  always_comb begin
    w_i_status = STAT_IDLE;
    w_d_status = STAT_IDLE;
    if (rst) begin
      if (i_req) w_i_status = STAT_BUSY;
      if (d_req) w_d_status = STAT_BUSY;
      case (r_state)
        S_GRANT_I: w_i_status = STAT_BUSY;
        S_GRANT_D: w_d_status = STAT_BUSY;
        S_RESP: begin
          if (r_last == SIDE_I) w_i_status = r_err ? STAT_ERR : STAT_DONE;
          else                  w_d_status = r_err ? STAT_ERR : STAT_DONE;
        end
        default: begin
        end
      endcase
    end
  end

  assign i_status = w_i_status;
  assign d_status = w_d_status;
  assign i_rdata  = r_i_rdata;
  assign d_rdata  = r_d_rdata;
  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign m_be     = r_m_be;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Directed vector bench for mem_arbiter (TIMEOUT = 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic [1:0]  i_status;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_rdata;
  logic [1:0]  d_status;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = '0;

  int n_pass  = 0;
  int n_total = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_status(i_status),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_rdata(d_rdata), .d_status(d_status),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_be(m_be), .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        we;        // also the expected m_we
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;        // also the expected m_be
    int          ack_cyc;   // 0 = never ack
    logic [31:0] mem_data;
    int          exp_hi;
    logic [1:0]  exp_stat;
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic run_txn(input int k, input vec_t v);
    int hi;
    hi = 0;
    @(posedge clk); #1;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    end else begin
      // junk on the idle D side must not leak into an I-side grant
      i_req = 1'b1; i_addr = v.addr;
      d_we = 1'b1; d_addr = 32'hFFFF_0000; d_wdata = 32'hA5A5_A5A5; d_be = 4'h0;
    end
    @(negedge clk);
    check($sformatf("v%0d_wait_status", k),
          32'(v.is_d ? d_status : i_status), 32'(2'b01));
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      m_ack   = (c == v.ack_cyc);
      m_rdata = (c == v.ack_cyc) ? v.mem_data : 32'hFEED_FACE;
      @(negedge clk);
      if (c == 1) begin
        check($sformatf("v%0d_m_addr", k), m_addr, v.addr);
        check($sformatf("v%0d_m_we", k), 32'(m_we), 32'(v.we));
        check($sformatf("v%0d_m_be", k), 32'(m_be), 32'(v.be));
        if (v.is_d) check($sformatf("v%0d_m_wdata", k), m_wdata, v.wdata);
      end
      if (!m_req) break;
      hi++;
    end
    m_ack = 1'b0;
    check($sformatf("v%0d_mreq_cycles", k), 32'(hi), 32'(v.exp_hi));
    check($sformatf("v%0d_resp_status", k),
          32'(v.is_d ? d_status : i_status), 32'(v.exp_stat));
    check($sformatf("v%0d_other_status", k),
          32'(v.is_d ? i_status : d_status), 32'(2'b00));
    check($sformatf("v%0d_i_rdata", k), i_rdata, v.exp_i_rdata);
    check($sformatf("v%0d_d_rdata", k), d_rdata, v.exp_d_rdata);
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("v%0d_after_status", k),
          32'(v.is_d ? d_status : i_status), 32'(2'b00));
    check($sformatf("v%0d_after_mreq", k), 32'(m_req), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          is_d we addr           wdata          be    ack mem            hi stat   i_rdata        d_rdata
    vecs[0] = '{1'b0, 1'b0, 32'h1000, 32'h0,         4'hF, 3, 32'h2402_0001, 3, 2'b10, 32'h2402_0001, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF, 2, 32'h1111_1111, 2, 2'b10, 32'h2402_0001, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h2004, 32'h0,         4'h3, 0, 32'h0,         4, 2'b11, 32'h2402_0001, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h2008, 32'h0,         4'hF, 1, 32'hCAFE_F00D, 1, 2'b10, 32'h2402_0001, 32'hCAFE_F00D};
    vecs[4] = '{1'b1, 1'b1, 32'h200C, 32'h1234_5678, 4'h5, 4, 32'h9999_9999, 4, 2'b10, 32'h2402_0001, 32'hCAFE_F00D};
    vecs[5] = '{1'b0, 1'b0, 32'h1004, 32'h0,         4'hF, 4, 32'h0BAD_C0DE, 4, 2'b10, 32'h0BAD_C0DE, 32'hCAFE_F00D};
    vecs[6] = '{1'b0, 1'b0, 32'h1008, 32'h0,         4'hF, 0, 32'h0,         4, 2'b11, 32'h0,         32'hCAFE_F00D};
    vecs[7] = '{1'b0, 1'b0, 32'h4000, 32'h0,         4'hF, 2, 32'h1357_2468, 2, 2'b10, 32'h1357_2468, 32'h0};

    // Reset values, sampled while reset is still asserted.
    i_req = 1'b1; d_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_i_status", 32'(i_status), 32'(2'b00));
    check("rst_d_status", 32'(d_status), 32'(2'b00));
    check("rst_m_req", 32'(m_req), 32'(0));
    check("rst_m_we", 32'(m_we), 32'(0));
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_m_wdata", m_wdata, 32'h0);
    check("rst_m_be", 32'(m_be), 32'(0));
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;

    // Stray ack while idle is ignored.
    @(posedge clk); #1 m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1 m_ack = 1'b0;
    @(negedge clk);
    check("stray_m_req", 32'(m_req), 32'(0));
    check("stray_i_rdata", i_rdata, 32'h0);
    check("stray_d_rdata", d_rdata, 32'h0);
    check("stray_i_status", 32'(i_status), 32'(2'b00));

    // Contention straight from reset: D, I, D, I with both held.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_addr = 32'h200; d_we = 1'b0; d_be = 4'hF; d_wdata = 32'h0;
    @(negedge clk);
    check("cont_wait_i", 32'(i_status), 32'(2'b01));
    check("cont_wait_d", 32'(d_status), 32'(2'b01));
    for (int k = 0; k < 4; k++) begin
      logic is_d;
      is_d = (k % 2 == 0);
      @(posedge clk); #1 m_ack = 1'b1; m_rdata = 32'hA000_0000 + 32'(k);
      @(negedge clk);
      check($sformatf("cont%0d_m_req", k), 32'(m_req), 32'(1));
      check($sformatf("cont%0d_m_addr", k), m_addr, is_d ? 32'h200 : 32'h100);
      check($sformatf("cont%0d_loser_busy", k),
            32'(is_d ? i_status : d_status), 32'(2'b01));
      @(posedge clk); #1 m_ack = 1'b0;
      @(negedge clk);
      check($sformatf("cont%0d_done", k),
            32'(is_d ? d_status : i_status), 32'(2'b10));
      check($sformatf("cont%0d_loser_busy2", k),
            32'(is_d ? i_status : d_status), 32'(2'b01));
      check($sformatf("cont%0d_rdata", k),
            is_d ? d_rdata : i_rdata, 32'hA000_0000 + 32'(k));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("cont%0d_gap_mreq", k), 32'(m_req), 32'(0));
      check($sformatf("cont%0d_gap_busy", k), 32'({i_status, d_status}), 32'(4'b0101));
      if (k == 3) begin i_req = 1'b0; d_req = 1'b0; end
    end

    // Vector table from a clean reset.
    reset_dut();
    for (int k = 0; k < 7; k++) run_txn(k, vecs[k]);

    // Requester drops req mid-grant; the access and DONE pulse still happen.
    @(posedge clk); #1 i_req = 1'b1; i_addr = 32'h3000;
    @(posedge clk); #1 i_req = 1'b0;
    @(negedge clk);
    check("drop_m_req", 32'(m_req), 32'(1));
    check("drop_busy", 32'(i_status), 32'(2'b01));
    @(posedge clk); #1 m_ack = 1'b1; m_rdata = 32'h55AA_55AA;
    @(posedge clk); #1 m_ack = 1'b0;
    @(negedge clk);
    check("drop_done", 32'(i_status), 32'(2'b10));
    check("drop_rdata", i_rdata, 32'h55AA_55AA);
    @(posedge clk);
    @(negedge clk);
    check("drop_idle", 32'(i_status), 32'(2'b00));

    // Reset during GRANT_I discards the access with no status pulse.
    @(posedge clk); #1 i_req = 1'b1; i_addr = 32'h4000;
    @(posedge clk);
    @(negedge clk);
    check("mrst_m_req_before", 32'(m_req), 32'(1));
    @(posedge clk); #1 rst = 1'b0; m_ack = 1'b1; m_rdata = 32'h7777_7777;
    @(negedge clk);
    check("mrst_status_in_rst", 32'(i_status), 32'(2'b00));
    @(posedge clk); #1 m_ack = 1'b0;
    @(negedge clk);
    check("mrst_m_req_after", 32'(m_req), 32'(0));
    check("mrst_i_rdata", i_rdata, 32'h0);
    i_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("mrst_no_pulse%0d", c), 32'(i_status), 32'(2'b00));
    end
    run_txn(7, vecs[7]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
